// File: rtl/token_encoder.sv
// Greedy longest-match tokenizer over a zero-terminated input string and packed vocabulary.
// Optional feature: define TOKEN_ENCODER_UNK_EN to emit UNK_CODE for unmatched characters instead of flagging err.
module token_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_AW      = 4,
  parameter int VOC_AW     = 6,
  parameter int CODE_W     = 4,
  parameter logic [CODE_W-1:0] UNK_CODE = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IN_AW-1:0]      in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [VOC_AW-1:0]     voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_data,
  output logic                  tok_valid,
  input  logic                  tok_ready,
  output logic [CODE_W-1:0]     tok_code,
  output logic [IN_AW:0]        tok_len,
  output logic [IN_AW:0]        tok_count,
  output logic                  err
);

  typedef enum logic [2:0] {IDLE, ADDR, CMP, SKIP, EMIT, DONE} state_t;

  localparam logic [IN_AW-1:0]  IN_LAST  = '1;
  localparam logic [VOC_AW-1:0] VOC_LAST = '1;

  state_t                  state;
  logic [IN_AW-1:0]        pos;
  logic [IN_AW:0]          k;
  logic [CODE_W-1:0]       idx;
  logic [IN_AW:0]          best_len;
  logic [CODE_W-1:0]       best_code;
  logic                    skip_wait;
  logic                    p_zero;
  logic [DATA_WIDTH-1:0]   in_char;

  // The last input address always reads as a terminator.
  always_comb begin
    in_char = in_data;
    if (in_addr == IN_LAST) in_char = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tok_valid <= 1'b0;
      tok_code  <= '0;
      tok_len   <= '0;
      tok_count <= '0;
      in_addr   <= '0;
      voc_addr  <= '0;
      pos       <= '0;
      k         <= '0;
      idx       <= '0;
      best_len  <= '0;
      best_code <= '0;
      skip_wait <= 1'b0;
      p_zero    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= ADDR;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            tok_count <= '0;
            in_addr   <= '0;
            voc_addr  <= '0;
            pos       <= '0;
            k         <= '0;
            idx       <= '0;
            best_len  <= '0;
            best_code <= '0;
          end
        end

        ADDR: state <= CMP;

        CMP: begin
          if (k == '0) p_zero <= (in_char == '0);
          if (k == '0 && in_char == '0) begin
            state <= EMIT;
          end else if (voc_addr == VOC_LAST) begin
            state <= EMIT;
          end else if (voc_data == '0) begin
            if (k == '0) begin
              state <= EMIT;
            end else begin
              // Strictly greater keeps the earlier entry on equal lengths.
              if (k > best_len) begin
                best_len  <= k;
                best_code <= idx;
              end
              voc_addr <= voc_addr + 1'b1;
              in_addr  <= pos;
              k        <= '0;
              idx      <= idx + 1'b1;
              state    <= ADDR;
            end
          end else if (voc_data == in_char) begin
            k        <= k + 1'b1;
            in_addr  <= in_addr + 1'b1;
            voc_addr <= voc_addr + 1'b1;
            state    <= ADDR;
          end else begin
            voc_addr  <= voc_addr + 1'b1;
            skip_wait <= 1'b1;
            state     <= SKIP;
          end
        end

        // Two cycles per vocabulary character: address, then sample.
        SKIP: begin
          if (skip_wait) begin
            skip_wait <= 1'b0;
          end else if (voc_addr == VOC_LAST) begin
            state <= EMIT;
          end else if (voc_data == '0) begin
            voc_addr <= voc_addr + 1'b1;
            in_addr  <= pos;
            k        <= '0;
            idx      <= idx + 1'b1;
            state    <= ADDR;
          end else begin
            voc_addr  <= voc_addr + 1'b1;
            skip_wait <= 1'b1;
          end
        end

        EMIT: begin
          if (!tok_valid) begin
            if (p_zero) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (best_len != '0) begin
              tok_valid <= 1'b1;
              tok_code  <= best_code;
              tok_len   <= best_len;
            end else begin
`ifdef TOKEN_ENCODER_UNK_EN
              tok_valid <= 1'b1;
              tok_code  <= UNK_CODE;
              tok_len   <= {{IN_AW{1'b0}}, 1'b1};
`else
              // tok_code shows UNK_CODE alongside err; tok_valid stays low.
              tok_code <= UNK_CODE;
              err      <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
`endif
            end
          end else if (tok_ready) begin
            tok_valid <= 1'b0;
            tok_count <= tok_count + 1'b1;
            pos       <= pos + tok_len[IN_AW-1:0];
            in_addr   <= pos + tok_len[IN_AW-1:0];
            voc_addr  <= '0;
            k         <= '0;
            idx       <= '0;
            best_len  <= '0;
            best_code <= '0;
            state     <= ADDR;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_token_encoder.sv
// Self-checking bench for token_encoder: string-level greedy model plus directed cases.
module tb_token_encoder;
  localparam int IAW = 4;
  localparam int VAW = 6;
  localparam int CW  = 4;
  localparam int UNK = 15;

  logic           clk = 1'b0;
  logic           rst, start, tok_ready;
  logic           busy, done, err, tok_valid;
  logic [IAW-1:0] in_addr;
  logic [VAW-1:0] voc_addr;
  logic [7:0]     in_data, voc_data;
  logic [CW-1:0]  tok_code;
  logic [IAW:0]   tok_len, tok_count;

  logic [7:0] in_mem  [16];
  logic [7:0] voc_mem [64];

  token_encoder #(.DATA_WIDTH(8), .IN_AW(IAW), .VOC_AW(VAW), .CODE_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .voc_addr(voc_addr), .voc_data(voc_data),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_code(tok_code),
    .tok_len(tok_len), .tok_count(tok_count), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    in_data  <= in_mem[in_addr];
    voc_data <= voc_mem[voc_addr];
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct { int code; int len; } tok_t;
  tok_t expq[$];
  int   exp_err;
  int   exp_count;
  int   voc_ptr;

  task automatic clear_mems();
    for (int i = 0; i < 16; i++) in_mem[i] = 8'd0;
    for (int i = 0; i < 64; i++) voc_mem[i] = 8'd0;
    voc_ptr = 0;
  endtask

  task automatic add_voc(string s);
    for (int i = 0; i < s.len(); i++) begin
      voc_mem[voc_ptr] = s[i];
      voc_ptr++;
    end
    voc_mem[voc_ptr] = 8'd0;
    voc_ptr++;
  endtask

  task automatic set_in(string s);
    for (int i = 0; i < s.len(); i++) in_mem[i] = s[i];
    in_mem[s.len()] = 8'd0;
  endtask

  // Greedy longest match computed directly on the strings.
  task automatic build_model();
    int st[$];
    int ln[$];
    int a, l, n, p, best, code, ok;
    tok_t t;
    a = 0;
    while (a < 63 && voc_mem[a] != 0) begin
      l = 0;
      while (a + l < 63 && voc_mem[a+l] != 0) l++;
      if (a + l >= 63) break;
      st.push_back(a);
      ln.push_back(l);
      a = a + l + 1;
    end
    n = 0;
    while (n < 15 && in_mem[n] != 0) n++;
    expq.delete();
    exp_err = 0;
    p = 0;
    while (p < n) begin
      best = 0;
      code = 0;
      for (int e = 0; e < st.size(); e++) begin
        if (ln[e] <= n - p) begin
          ok = 1;
          for (int j = 0; j < ln[e]; j++)
            if (voc_mem[st[e]+j] != in_mem[p+j]) ok = 0;
          if (ok == 1 && ln[e] > best) begin
            best = ln[e];
            code = e % 16;
          end
        end
      end
      if (best > 0) begin
        t.code = code; t.len = best;
        expq.push_back(t);
        p = p + best;
      end else begin
`ifdef TOKEN_ENCODER_UNK_EN
        t.code = UNK; t.len = 1;
        expq.push_back(t);
        p = p + 1;
`else
        exp_err = 1;
        break;
`endif
      end
    end
    exp_count = expq.size();
  endtask

  // Per-cycle output checker.
  logic mon_en = 1'b0;
  int   xfers = 0;
  logic prev_stall = 1'b0;
  int   prev_code, prev_len;
  tok_t cur;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("tok_count_running", int'(tok_count), xfers);
      if (prev_stall) begin
        chk("stall_valid", int'(tok_valid), 1);
        chk("stall_code", int'(tok_code), prev_code);
        chk("stall_len", int'(tok_len), prev_len);
      end
      if (tok_valid && tok_ready) begin
        chk("token_expected", int'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          cur = expq.pop_front();
          chk("tok_code", int'(tok_code), cur.code);
          chk("tok_len", int'(tok_len), cur.len);
        end
        xfers++;
      end
      prev_stall = tok_valid && !tok_ready;
      prev_code  = int'(tok_code);
      prev_len   = int'(tok_len);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_zero(string tag);
    @(negedge clk);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_tok_valid"}, int'(tok_valid), 0);
    chk({tag, "_tok_count"}, int'(tok_count), 0);
    chk({tag, "_tok_code"}, int'(tok_code), 0);
    chk({tag, "_tok_len"}, int'(tok_len), 0);
    chk({tag, "_in_addr"}, int'(in_addr), 0);
    chk({tag, "_voc_addr"}, int'(voc_addr), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    mon_en = 1'b0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    xfers  = 0;
    mon_en = 1'b1;
  endtask

  task automatic run_case(string tag, bit stall);
    int cyc, scnt;
    cyc = 0;
    scnt = 0;
    tok_ready = stall ? 1'b0 : 1'b1;
    pulse_start();
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (stall && tok_valid && !tok_ready) begin
        scnt++;
        if (scnt == 5) begin
          chk({tag, "_stall_code_lit"}, int'(tok_code), 2);
          chk({tag, "_stall_count_lit"}, int'(tok_count), 0);
          @(posedge clk); #1;
          tok_ready = 1'b1;
        end
      end
    end
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err), exp_err);
    chk({tag, "_tok_count"}, int'(tok_count), exp_count);
    chk({tag, "_leftover"}, expq.size(), 0);
    if (stall) chk({tag, "_stall_seen"}, scnt, 5);
  endtask

  task automatic load_abc();
    clear_mems();
    add_voc("a"); add_voc("ab"); add_voc("abc"); add_voc("b");
    set_in("abcab");
    build_model();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tok_ready = 1'b1;
    clear_mems();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");

    // Basic longest match
    load_abc();
    chk("m1_size", expq.size(), 2);
    chk("m1_c0", expq[0].code, 2); chk("m1_l0", expq[0].len, 3);
    chk("m1_c1", expq[1].code, 1); chk("m1_l1", expq[1].len, 2);
    run_case("abcab", 1'b0);

    // Back-pressure on the first token
    load_abc();
    run_case("stall", 1'b1);

    // Reset while comparing, then rerun
    load_abc();
    tok_ready = 1'b1;
    pulse_start();
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("midrst");
    run_case("rerun", 1'b0);

    // Duplicate entries: earlier code wins
    clear_mems();
    add_voc("ab"); add_voc("ab");
    set_in("ab");
    build_model();
    chk("m3_size", expq.size(), 1);
    chk("m3_c0", expq[0].code, 0); chk("m3_l0", expq[0].len, 2);
    run_case("dup", 1'b0);

    // Unmatched character
    clear_mems();
    add_voc("a"); add_voc("b");
    set_in("azb");
    build_model();
`ifdef TOKEN_ENCODER_UNK_EN
    chk("m4_size", expq.size(), 3);
    chk("m4_c1", expq[1].code, UNK);
    chk("m4_c2", expq[2].code, 1);
    chk("m4_err", exp_err, 0);
`else
    chk("m4_size", expq.size(), 1);
    chk("m4_c0", expq[0].code, 0);
    chk("m4_err", exp_err, 1);
`endif
    run_case("unk", 1'b0);

    // Empty input
    clear_mems();
    add_voc("a"); add_voc("b");
    set_in("");
    build_model();
    chk("m5_size", expq.size(), 0);
    run_case("empty", 1'b0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/token_encoder.md
TOKEN_ENCODER -- requirements
Module: token_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: character width in bits; value 0 is the terminator.
REQ-002 SHALL have parameter IN_AW, default 4: input-memory address width.
REQ-003 SHALL have parameter VOC_AW, default 6: vocabulary-memory address width.
REQ-004 SHALL have parameter CODE_W, default 4: token code width; the code is the vocabulary entry index.
REQ-005 SHALL have parameter UNK_CODE, default all-ones of CODE_W: code emitted for an unmatched character.
REQ-006 SHALL have port clk  in  1  rising-edge clock; the block uses one clock; reset is synchronous and active-high.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port start  in  1  one-cycle pulse that begins encoding at input address 0.
REQ-009 SHALL have ports busy  out  1  and done  out  1; done is sticky high after completion until the next accepted start.
REQ-010 SHALL have ports in_addr  out  IN_AW  and in_data  in  DATA_WIDTH  for the input-string memory read port.
REQ-011 SHALL have ports voc_addr  out  VOC_AW  and voc_data  in  DATA_WIDTH  for the vocabulary memory read port.
REQ-012 SHALL have ports tok_valid  out  1, tok_ready  in  1, tok_code  out  CODE_W, and tok_len  out  IN_AW+1 as the token output stream.
REQ-013 SHALL have ports tok_count  out  IN_AW+1  giving tokens emitted since start, and err  out  1.

Function
REQ-014 SHALL treat both memories as 1-cycle read latency: data for an address driven in cycle N is sampled in cycle N+1.
REQ-015 SHALL read vocabulary entries as zero-terminated strings packed from address 0; an entry whose first character is 0 ends the vocabulary.
REQ-016 SHALL perform greedy longest-match: at input position p, compare each entry against in[p..]; an entry matches with length k if its k characters equal in[p..p+k-1] and its terminator is reached.
REQ-017 SHALL stop comparing an entry on mismatch or on input terminator, then advance voc_addr past that entry's terminator.
REQ-018 SHALL, on equal match lengths, keep the earlier (lower-code) entry.
REQ-019 SHALL use states IDLE, ADDR, CMP, SKIP, EMIT, DONE: IDLE->ADDR on start; ADDR->CMP after one cycle; CMP->ADDR/SKIP/next entry; end of vocabulary->EMIT; EMIT->ADDR at p+best_len, or DONE if in[p]==0.
REQ-020 SHALL hold tok_valid, tok_code and tok_len stable while tok_valid=1 and tok_ready=0; the transfer occurs on a cycle where both are 1.
REQ-021 SHALL increment tok_count once per completed transfer.
REQ-022 SHALL enter DONE without emitting a token when in[p]==0; for empty input, tok_count is 0.
REQ-023 SHALL treat voc_addr reaching 2^VOC_AW-1 without a terminator as end of vocabulary.
REQ-024 SHALL treat in_addr reaching 2^IN_AW-1 as an input terminator.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL, when a start arrives in DONE, clear done, err and tok_count and begin again.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, return to IDLE and set busy, done, err, tok_valid to 0 and tok_count, tok_code, tok_len, in_addr, voc_addr to 0.
REQ-028 SHALL, on reset during an operation, abort it with no partial token transferred; any tok_valid is dropped.

Configuration
REQ-029 SHALL, with TOKEN_ENCODER_UNK_EN defined, handle a position with no matching entry by emitting tok_code=UNK_CODE with tok_len=1, advancing p by 1, and leaving err at 0.
REQ-030 SHALL, without TOKEN_ENCODER_UNK_EN, handle a position with no matching entry by setting err=1 and entering DONE with done=1, emitting no token for that position.

Verification
REQ-031 SHALL verify: vocab "a","ab","abc","b" (codes 0-3), input "abcab" -> tokens (2,len3),(1,len2); tok_count=2; done=1, err=0.
REQ-032 SHALL verify: same case with tok_ready held low 5 cycles at the first token -> tok_code=2 stable through the stall; tok_count=1 only after the transfer.
REQ-033 SHALL verify: vocab "ab","ab", input "ab" -> single token, code 0, len 2.
REQ-034 SHALL verify: input "azb" with vocab "a","b" -> with macro: codes 0,UNK_CODE,1, err=0; without macro: code 0, then err=1 and done=1, tok_count=1.
REQ-035 SHALL verify: input first character 0 -> done=1 with no tok_valid; tok_count=0.
REQ-036 SHALL verify: rst pulsed during CMP of "abcab" -> next cycle state IDLE and all outputs 0; a new start reproduces the REQ-031 result.
